temporal_encoder: RTL and testbench



---
 rtl/temporal_pkg.sv | 22 ++
 rtl/temporal_enc_ch.sv | 49 ++++
 rtl/temporal_encoder.sv | 122 ++++++++++++
 tb/tb_temporal_encoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/temporal_pkg.sv
// Shared types and helpers for the race-logic temporal encoder.
package temporal_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

  // Idle level of a rising-edge encoder; falling-edge encoding inverts it.
  localparam logic RISING_IDLE = 1'b0;

  function automatic logic idle_level(input int falling);
    return RISING_IDLE ^ (falling != 0);
  endfunction

  // A value that cannot produce an edge before the gamma wraps counts as infinity.
  function automatic logic is_inf(input int unsigned v, input logic inf_flag,
                                  input int unsigned gamma_len);
    return inf_flag || (v >= gamma_len - 1);
  endfunction

endpackage

// File: rtl/temporal_enc_ch.sv
// One temporal output channel: compares the gamma counter to the channel value and
// registers the spike. TEMPORAL_ENC_PULSE_EN selects single-cycle pulse encoding.
module temporal_enc_ch
  import temporal_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int GAMMA_LEN = 10,
  parameter int FALLING   = 0,
  parameter int CNT_W     = 4
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic [CNT_W-1:0] t_cnt,
  input  logic             grst_cyc,
  input  logic [WIDTH-1:0] value,
  input  logic             inf,
  output logic             spike
);

  localparam logic             IDLE_LVL = idle_level(FALLING);
  localparam logic [CNT_W-1:0] T_LAST   = CNT_W'(GAMMA_LEN - 1);

  logic fire;

  // Firing at t_cnt==value puts the registered edge at t_cnt==value+1. A zero value
  // matches the idle counter too, so it is qualified by the gamma-reset cycle.
  assign fire = !is_inf(32'(value), inf, GAMMA_LEN)
             && (32'(t_cnt) == 32'(value))
             && ((value != '0) || grst_cyc);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge aclk) begin
    if (!rst) begin
      spike <= IDLE_LVL;
    end else begin
`ifdef TEMPORAL_ENC_PULSE_EN
      spike <= fire ? ~IDLE_LVL : IDLE_LVL;
`else
      if (fire) begin
        spike <= ~IDLE_LVL;
      end else if (t_cnt == T_LAST) begin
        spike <= IDLE_LVL;
      end
`endif
    end
  end

endmodule

// File: rtl/temporal_encoder.sv
// Binary-to-temporal encoder: FSM, gamma counter, valid/ready shadow buffer and
// active register feeding NUM_CH channels. Optional macro: TEMPORAL_ENC_PULSE_EN.
module temporal_encoder
  import temporal_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int WIDTH     = 3,
  parameter int GAMMA_LEN = 10,
  parameter int FALLING   = 0
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_inf,
  output logic                    grst,
  output logic [NUM_CH-1:0]       spike,
  output logic                    busy
);

  localparam int               CNT_W  = (GAMMA_LEN > 1) ? $clog2(GAMMA_LEN) : 1;
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(GAMMA_LEN - 1);

  enc_state_t              state, state_next;
  logic [CNT_W-1:0]        t_cnt, t_next;
  logic                    grst_next;
  logic                    pending;
  logic                    accept;
  logic [NUM_CH*WIDTH-1:0] shadow_data, active_data, eff_data;
  logic [NUM_CH-1:0]       shadow_inf, active_inf, eff_inf;

  assign accept   = in_valid && !pending;
  assign in_ready = !pending;
  assign busy     = (state != IDLE);

  // NOTE: every variable written here gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    t_next     = t_cnt;
    unique case (state)
      IDLE: begin
        t_next = '0;
        if (en) state_next = RUN;
      end
      RUN: begin
        if (t_cnt == T_LAST) begin
          t_next = '0;
          if (!en) state_next = IDLE;
        end else begin
          t_next = t_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    grst_next = (state_next == RUN) && (t_next == '0);
  end

  // In the boundary cycle channels see the bundle that is about to become active,
  // so a zero value can already fire for t_cnt==1.
  always_comb begin
    eff_data = active_data;
    eff_inf  = active_inf;
    if (grst) begin
      if (pending) begin
        eff_data = shadow_data;
        eff_inf  = shadow_inf;
      end else begin
        eff_data = '0;
        eff_inf  = '1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!rst) begin
      state       <= IDLE;
      t_cnt       <= '0;
      grst        <= 1'b0;
      pending     <= 1'b0;
      shadow_data <= '0;
      shadow_inf  <= '1;
      active_data <= '0;
      active_inf  <= '1;
    end else begin
      state <= state_next;
      t_cnt <= t_next;
      grst  <= grst_next;
      if (grst) begin
        active_data <= eff_data;
        active_inf  <= eff_inf;
      end
      // accept implies pending was clear, so it never collides with the transfer.
      if (accept) begin
        shadow_data <= in_data;
        shadow_inf  <= in_inf;
        pending     <= 1'b1;
      end else if (grst) begin
        pending <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    temporal_enc_ch #(
      .WIDTH    (WIDTH),
      .GAMMA_LEN(GAMMA_LEN),
      .FALLING  (FALLING),
      .CNT_W    (CNT_W)
    ) u_ch (
      .aclk    (aclk),
      .rst     (rst),
      .t_cnt   (t_cnt),
      .grst_cyc(grst),
      .value   (eff_data[i*WIDTH +: WIDTH]),
      .inf     (eff_inf[i]),
      .spike   (spike[i])
    );
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// Scoreboard bench for temporal_encoder: a rising-edge and a falling-edge instance
// share stimulus and are checked against a per-cycle behavioural model.
module tb_temporal_encoder;

  localparam int NUM_CH = 2;
  localparam int WIDTH  = 3;
  localparam int GL     = 10;

  logic                    aclk = 1'b0;
  logic                    rst, en, in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_inf;
  logic                    in_ready, grst, busy;
  logic [NUM_CH-1:0]       spike;
  logic                    in_ready_f, grst_f, busy_f;
  logic [NUM_CH-1:0]       spike_f;

  always #5 aclk = ~aclk;

  temporal_encoder #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .GAMMA_LEN(GL), .FALLING(0)) dut (
    .aclk(aclk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inf(in_inf), .grst(grst), .spike(spike), .busy(busy)
  );

  temporal_encoder #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .GAMMA_LEN(GL), .FALLING(1)) dut_f (
    .aclk(aclk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_f),
    .in_data(in_data), .in_inf(in_inf), .grst(grst_f), .spike(spike_f), .busy(busy_f)
  );

  typedef struct packed {
    logic              grst;
    logic [NUM_CH-1:0] spike;
    logic              in_ready;
    logic              busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model state describes the cycle currently being presented by the DUT.
  bit                      m_run, m_pend;
  int                      m_t;
  logic [NUM_CH*WIDTH-1:0] m_sh_d, m_cur_d;
  logic [NUM_CH-1:0]       m_sh_i, m_cur_i;

  function automatic exp_t model_out();
    exp_t e;
    e.grst     = m_run && (m_t == 0);
    e.in_ready = !m_pend;
    e.busy     = m_run;
    for (int i = 0; i < NUM_CH; i++) begin
      int v;
      bit on;
      v  = int'(m_cur_d[i*WIDTH +: WIDTH]);
      on = m_run && (m_t >= 1) && !m_cur_i[i] && (v < GL - 1);
`ifdef TEMPORAL_ENC_PULSE_EN
      on = on && (m_t == v + 1);
`else
      on = on && (m_t >= v + 1);
`endif
      e.spike[i] = on;
    end
    return e;
  endfunction

  task automatic step(output bit acc);
    exp_t e;
    acc = rst && in_valid && !m_pend;
    if (!rst) begin
      m_run = 0; m_t = 0; m_pend = 0;
      m_sh_d = '0; m_sh_i = '1; m_cur_d = '0; m_cur_i = '1;
    end else begin
      if (m_run && m_t == 0) begin
        if (m_pend) begin
          m_cur_d = m_sh_d; m_cur_i = m_sh_i;
        end else begin
          m_cur_d = '0; m_cur_i = '1;
        end
        m_pend = 0;
      end
      if (acc) begin
        m_sh_d = in_data; m_sh_i = in_inf; m_pend = 1;
      end
      if (!m_run) begin
        if (en) begin m_run = 1; m_t = 0; end
      end else if (m_t == GL - 1) begin
        m_t = 0;
        if (!en) m_run = 0;
      end else begin
        m_t++;
      end
    end
    exp_q.push_back(model_out());
    @(posedge aclk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    checks += 8;
    if (grst !== e.grst) begin errors++; $display("FAIL grst cyc=%0d got=%b expected=%b", cyc, grst, e.grst); end
    if (spike !== e.spike) begin errors++; $display("FAIL spike cyc=%0d got=%b expected=%b", cyc, spike, e.spike); end
    if (in_ready !== e.in_ready) begin errors++; $display("FAIL in_ready cyc=%0d got=%b expected=%b", cyc, in_ready, e.in_ready); end
    if (busy !== e.busy) begin errors++; $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy, e.busy); end
    if (grst_f !== e.grst) begin errors++; $display("FAIL grst_f cyc=%0d got=%b expected=%b", cyc, grst_f, e.grst); end
    if (spike_f !== ~e.spike) begin errors++; $display("FAIL spike_f cyc=%0d got=%b expected=%b", cyc, spike_f, ~e.spike); end
    if (in_ready_f !== e.in_ready) begin errors++; $display("FAIL in_ready_f cyc=%0d got=%b expected=%b", cyc, in_ready_f, e.in_ready); end
    if (busy_f !== e.busy) begin errors++; $display("FAIL busy_f cyc=%0d got=%b expected=%b", cyc, busy_f, e.busy); end
  endtask

  task automatic tick(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(a);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; in_inf = '0;
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_idle_gamma();
    int n_grst = 0;
    bit a;
    en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step(a);
      if (grst === 1'b1) n_grst++;
    end
    checks++;
    if (n_grst !== 3) begin errors++; $display("FAIL idle_grst_count got=%0d expected=3", n_grst); end
  endtask

  task automatic test_load();
    int  gcyc = -100, d0 = -1, d1 = -1;
    bit  a;
    for (int k = 0; k < 20 && !(m_run && m_t == 5); k++) step(a);
    in_data = {3'd5, 3'd2}; in_inf = 2'b00; in_valid = 1'b1;
    step(a);
    in_valid = 1'b0;
    for (int k = 0; k < 22; k++) begin
      step(a);
      if (grst === 1'b1) gcyc = cyc;
      if (spike[0] === 1'b1 && d0 < 0) d0 = cyc - gcyc;
      if (spike[1] === 1'b1 && d1 < 0) d1 = cyc - gcyc;
    end
    checks += 2;
    if (d0 !== 3) begin errors++; $display("FAIL ch0_delay got=%0d expected=3", d0); end
    if (d1 !== 6) begin errors++; $display("FAIL ch1_delay got=%0d expected=6", d1); end
  endtask

  task automatic test_back_to_back();
    int stage = 0;
    bit a;
    in_data = {3'd1, 3'd1}; in_inf = 2'b00; in_valid = 1'b1;
    for (int k = 0; k < 40 && stage < 2; k++) begin
      step(a);
      if (a) begin
        stage++;
        if (stage == 1) begin
          in_data = {3'd6, 3'd4}; in_inf = 2'b10;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (stage !== 2) begin errors++; $display("FAIL b2b_accepts got=%0d expected=2", stage); end
    in_valid = 1'b0;
    tick(35);
  endtask

  task automatic test_en_drop();
    int n_grst = 0;
    bit a;
    for (int k = 0; k < 20 && !(m_run && m_t == 4); k++) step(a);
    en = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(a);
      if (grst === 1'b1) n_grst++;
    end
    checks += 2;
    if (n_grst !== 0) begin errors++; $display("FAIL en_drop_grst got=%0d expected=0", n_grst); end
    if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_busy got=%b expected=0", busy); end
  endtask

  task automatic test_reset_mid();
    in_data = {3'd7, 3'd0}; in_inf = 2'b00; in_valid = 1'b1; en = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(1);
    in_data = {3'd2, 3'd3}; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(3);
`ifndef TEMPORAL_ENC_PULSE_EN
    checks++;
    if (spike[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_spike0 got=%b expected=1", spike[0]); end
`endif
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_pending got=%b expected=0", in_ready); end
    rst = 1'b0;
    tick(1);
    rst = 1'b1; en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(12);
    en = 1'b0;
    tick(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_gamma();
    test_load();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
